// File: rtl/evt_capture_pkg.sv
// evt_capture_pkg: edge mode encodings and edge selection helper shared by the event capture block
package evt_capture_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {EM_OFF = 2'd0, EM_POS = 2'd1, EM_NEG = 2'd2, EM_ANY = 2'd3} edge_mode_e;
  function automatic logic edge_sel(edge_mode_e m, logic r, logic f);
    return (m == EM_POS) ? r : (m == EM_NEG) ? f : (m == EM_ANY) ? (r | f) : 1'b0;
  endfunction
endpackage

// File: rtl/evt_capture_if.sv
// evt_capture_if: control inputs and count/flag outputs of the event capture block
interface evt_capture_if
  import evt_capture_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int HOLDOFF_W = 8
);
  logic [NUM_CH-1:0]        sig_i;
  logic [NUM_CH-1:0]        qual_i;
  logic [MODE_W*NUM_CH-1:0] mode_i;
  logic [HOLDOFF_W-1:0]     holdoff_i;
  logic [CNT_W-1:0]         thresh_i;
  logic [NUM_CH-1:0]        clr_i;
  logic [NUM_CH*CNT_W-1:0]  count_o;
  logic [NUM_CH-1:0]        hit_o;
  logic [NUM_CH-1:0]        sat_o;
  modport master (output sig_i, qual_i, mode_i, holdoff_i, thresh_i, clr_i, input count_o, hit_o, sat_o);
  modport slave (input sig_i, qual_i, mode_i, holdoff_i, thresh_i, clr_i, output count_o, hit_o, sat_o);
endinterface

// File: rtl/evt_capture_ch.sv
// evt_capture_ch: one channel of edge detection, holdoff blanking, saturating count, hit and sat flags
module evt_capture_ch
  import evt_capture_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int HOLDOFF_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_i,
  input  logic                 qual_i,
  input  edge_mode_e           mode_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic [CNT_W-1:0]     thresh_i,
  input  logic                 clr_i,
  output logic [CNT_W-1:0]     count_o,
  output logic                 hit_o,
  output logic                 sat_o
);
  logic                 sig_q, hit_q, hit_d, sat_q, sat_d, ev, inc;
  logic [HOLDOFF_W-1:0] ho_q, ho_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  // A saturated event still restarts holdoff but no longer increments or hits
  always_comb begin
    ev      = edge_sel(mode_i, sig_i & ~sig_q, ~sig_i & sig_q) & qual_i & (ho_q == '0);
    inc     = ev & ~&cnt_q;
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = clr_i ? '0 : inc ? cnt_inc : cnt_q;
    ho_d    = clr_i ? '0 : ev ? holdoff_i : (ho_q != '0) ? ho_q - 1'b1 : ho_q;
    hit_d   = ~clr_i & inc & (cnt_inc == thresh_i) & (thresh_i != '0);
    sat_d   = ~clr_i & (sat_q | (inc & &cnt_inc));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
      ho_q  <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
      ho_q  <= ho_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      sat_q <= sat_d;
    end
  end
  assign count_o = cnt_q;
  assign hit_o   = hit_q;
  assign sat_o   = sat_q;
endmodule

// File: rtl/evt_capture.sv
// evt_capture: NUM_CH independent edge event counters with shared holdoff and hit threshold
module evt_capture
  import evt_capture_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int HOLDOFF_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  evt_capture_if.slave bus
);
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    evt_capture_ch #(.CNT_W(CNT_W), .HOLDOFF_W(HOLDOFF_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig_i    (bus.sig_i[n]),
      .qual_i   (bus.qual_i[n]),
      .mode_i   (edge_mode_e'(bus.mode_i[MODE_W*n +: MODE_W])),
      .holdoff_i(bus.holdoff_i),
      .thresh_i (bus.thresh_i),
      .clr_i    (bus.clr_i[n]),
      .count_o  (bus.count_o[n*CNT_W +: CNT_W]),
      .hit_o    (bus.hit_o[n]),
      .sat_o    (bus.sat_o[n])
    );
  end
endmodule

// File: tb/tb_evt_capture.sv
// tb_evt_capture: table-driven, directed and randomized checks of evt_capture against a cycle model
module tb_evt_capture;
  localparam int NC = 4;
  localparam int CW = 4;
  localparam int HW = 8;
  localparam int MAXC = (1 << CW) - 1;
  typedef struct {
    logic [NC-1:0]    sig;
    logic [NC-1:0]    qual;
    logic [2*NC-1:0]  mode;
    logic [HW-1:0]    ho;
    logic [CW-1:0]    thr;
    logic [NC-1:0]    clr;
    logic [NC*CW-1:0] ecnt;
  } row_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   m_cnt[NC];
  int   m_ho[NC];
  bit   m_prev[NC];
  bit   m_sat[NC];
  bit   m_hit[NC];
  row_t tbl[$];
  evt_capture_if #(.NUM_CH(NC), .CNT_W(CW), .HOLDOFF_W(HW)) bus ();
  evt_capture #(.NUM_CH(NC), .CNT_W(CW), .HOLDOFF_W(HW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0; m_ho[c] = 0; m_prev[c] = 0; m_sat[c] = 0; m_hit[c] = 0;
    end
  endtask
  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      bit s, r, f, det, ev;
      int md;
      s   = bus.sig_i[c];
      r   = s && !m_prev[c];
      f   = !s && m_prev[c];
      md  = int'(bus.mode_i[2*c +: 2]);
      det = (md == 1 && r) || (md == 2 && f) || (md == 3 && (r || f));
      ev  = det && bus.qual_i[c] && m_ho[c] == 0;
      m_hit[c] = 0;
      if (bus.clr_i[c]) begin
        m_cnt[c] = 0; m_ho[c] = 0; m_sat[c] = 0;
      end else begin
        m_ho[c] = ev ? int'(bus.holdoff_i) : (m_ho[c] > 0 ? m_ho[c] - 1 : 0);
        if (ev && m_cnt[c] < MAXC) begin
          m_cnt[c]++;
          m_hit[c] = (m_cnt[c] == int'(bus.thresh_i));
          if (m_cnt[c] == MAXC) m_sat[c] = 1;
        end
      end
      m_prev[c] = s;
    end
  endtask
  task automatic cyc();
    logic [NC*CW-1:0] ec;
    logic [NC-1:0] eh, es;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < NC; c++) begin
      ec[c*CW +: CW] = CW'(m_cnt[c]);
      eh[c] = m_hit[c];
      es[c] = m_sat[c];
    end
    check("model_count", 32'(bus.count_o), 32'(ec));
    check("model_hit", 32'(bus.hit_o), 32'(eh));
    check("model_sat", 32'(bus.sat_o), 32'(es));
  endtask
  task automatic drive(logic [NC-1:0] s, q, logic [2*NC-1:0] m, logic [HW-1:0] h, logic [CW-1:0] t, logic [NC-1:0] c);
    bus.sig_i = s; bus.qual_i = q; bus.mode_i = m; bus.holdoff_i = h; bus.thresh_i = t; bus.clr_i = c;
  endtask
  task automatic add(bit s, bit q, int m, int h, int c, int e);
    row_t r;
    r.sig = NC'(s); r.qual = NC'(q); r.mode = (2*NC)'(m); r.ho = HW'(h);
    r.thr = '0; r.clr = NC'(c); r.ecnt = (NC*CW)'(e);
    tbl.push_back(r);
  endtask
  initial begin
    int hits;
    for (int i = 0; i < 10; i++) add(i % 2 == 0, 1, 1, 0, 0, i / 2 + 1);
    add(0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(i % 2 == 0, 1, 3, 3, 0, i < 4 ? 1 : 2);
    add(0, 1, 2, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(i % 2 == 0, !(i == 3 || i == 7), 2, 0, 0, i >= 5 ? 2 : i >= 1 ? 1 : 0);
    add(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(i % 2 == 0, 1, 0, 0, 0, 0);
    drive('0, '0, '0, '0, '0, '0);
    model_reset();
    @(negedge clk);
    check("reset_count", 32'(bus.count_o), 0);
    check("reset_hit", 32'(bus.hit_o), 0);
    check("reset_sat", 32'(bus.sat_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc();
    foreach (tbl[i]) begin
      drive(tbl[i].sig, tbl[i].qual, tbl[i].mode, tbl[i].ho, tbl[i].thr, tbl[i].clr);
      cyc();
      check($sformatf("tbl%0d_count", i), 32'(bus.count_o), 32'(tbl[i].ecnt));
      check($sformatf("tbl%0d_hit", i), 32'(bus.hit_o), 0);
    end
    drive(4'h0, 4'h1, 8'h01, 0, 4'd3, 4'hF);
    cyc();
    bus.clr_i = '0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      bus.sig_i = 4'h1;
      cyc();
      hits += int'(bus.hit_o[0]);
      check("sat_seq_count", 32'(bus.count_o[CW-1:0]), (i + 1 > MAXC) ? MAXC : i + 1);
      check("sat_seq_hit", 32'(bus.hit_o[0]), 32'(i == 2));
      check("sat_seq_sat", 32'(bus.sat_o[0]), 32'(i >= 14));
      bus.sig_i = 4'h0;
      cyc();
      hits += int'(bus.hit_o[0]);
    end
    check("sat_seq_hits", hits, 1);
    drive(4'h0, 4'h1, 8'h01, 0, 4'd8, 4'hF);
    cyc();
    bus.clr_i = '0;
    for (int i = 0; i < 7; i++) begin
      bus.sig_i = 4'h1; cyc();
      bus.sig_i = 4'h0; cyc();
    end
    check("clr_pre_count", 32'(bus.count_o[CW-1:0]), 7);
    bus.sig_i = 4'h1; bus.clr_i = 4'h1;
    cyc();
    check("clr_count", 32'(bus.count_o[CW-1:0]), 0);
    check("clr_hit", 32'(bus.hit_o[0]), 0);
    check("clr_sat", 32'(bus.sat_o[0]), 0);
    bus.sig_i = 4'h0; bus.clr_i = 4'h0; cyc();
    bus.sig_i = 4'h1; cyc();
    check("clr_next_count", 32'(bus.count_o[CW-1:0]), 1);
    drive(4'h0, 4'hF, 8'h55, 0, 0, 4'hF);
    cyc();
    bus.clr_i = '0; bus.sig_i = 4'hF;
    cyc();
    check("all_ch_count", 32'(bus.count_o), 32'h1111);
    drive(4'h0, 4'h1, 8'h01, 8'd10, 0, 4'hF);
    cyc();
    bus.clr_i = '0;
    cyc();
    bus.sig_i = 4'h1;
    repeat (5) cyc();
    check("ho_pre_count", 32'(bus.count_o[CW-1:0]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(bus.count_o), 0);
    check("async_rst_hit", 32'(bus.hit_o), 0);
    check("async_rst_sat", 32'(bus.sat_o), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("post_rst_count", 32'(bus.count_o[CW-1:0]), 1);
    for (int i = 0; i < 1500; i++) begin
      logic [NC-1:0] c;
      for (int k = 0; k < NC; k++) c[k] = ($urandom_range(0, 15) == 0);
      drive(NC'($urandom), NC'($urandom | $urandom), (2*NC)'($urandom), HW'($urandom_range(0, 3)), CW'($urandom_range(0, 15)), c);
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
